// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one fixed-latency memory port between fetch and data ports
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic       PORT_I = 1'b0;
    localparam logic       PORT_D = 1'b1;
    localparam logic [3:0] LAT    = 4'(LATENCY);

    state_t      state;
    logic        owner;
    logic        last;
    logic        write_op;
    logic [3:0]  count;
    logic        winner;
    logic [31:0] sel_addr;
    logic        unused_addr_bits;

    // On a tie the port that did not win last time gets the memory.
    always_comb begin
        winner   = (i_req && d_req) ? ~last : d_req;
        sel_addr = (winner == PORT_D) ? d_addr : i_addr;
    end

    assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= PORT_I;
            last      <= PORT_D;
            write_op  <= 1'b0;
            count     <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner     <= winner;
                        last      <= winner;
                        write_op  <= (winner == PORT_D) && d_we;
                        mem_en    <= 1'b1;
                        mem_we    <= (winner == PORT_D) && d_we;
                        mem_addr  <= sel_addr[ADDR_W+1:2];
                        mem_wdata <= (winner == PORT_D) ? d_wdata : '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    count     <= LAT;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (count == 4'd1) begin
                        // Read data is valid only on the last wait cycle; writes leave d_rdata alone.
                        if (owner == PORT_I) begin
                            i_rdata <= mem_rdata;
                            i_ack   <= 1'b1;
                        end else begin
                            if (!write_op) d_rdata <= mem_rdata;
                            d_ack <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
